// File: rtl/updown_counter_mod.sv
// Parametrised up/down counter with run-time modulus, parallel load,
// wrap/saturate mode, terminal flags and a saturating wrap-event counter.
module updown_counter_mod #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned RESET_VAL = 0,
    parameter int unsigned WRAP_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              up,
    input  logic              sat_mode,
    input  logic [WIDTH-1:0]  max_val,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    input  logic              clr_wrap,
    output logic [WIDTH-1:0]  count,
    output logic              at_max,
    output logic              at_zero,
    output logic              ovf,
    output logic              unf,
    output logic [WRAP_W-1:0] wrap_cnt
);

    logic [WIDTH-1:0]  r_count;
    logic              r_ovf;
    logic              r_unf;
    logic [WRAP_W-1:0] r_wrap;

    logic [WIDTH-1:0]  w_count_nxt;
    logic              w_ovf_nxt;
    logic              w_unf_nxt;
    logic              w_at_max;
    logic              w_at_zero;

    assign w_at_max  = (r_count == max_val);
    assign w_at_zero = (r_count == '0);

    always_comb begin
        w_count_nxt = r_count;
        w_ovf_nxt   = 1'b0;
        w_unf_nxt   = 1'b0;
        if (load) begin
            w_count_nxt = (load_val > max_val) ? max_val : load_val;
        end else if (en) begin
            // A lowered max_val pulls the count back into range before any step.
            if (r_count > max_val) begin
                w_count_nxt = max_val;
            end else if (up) begin
                if (w_at_max) begin
                    w_ovf_nxt   = 1'b1;
                    w_count_nxt = sat_mode ? r_count : '0;
                end else begin
                    w_count_nxt = r_count + 1'b1;
                end
            end else begin
                if (w_at_zero) begin
                    w_unf_nxt   = 1'b1;
                    w_count_nxt = sat_mode ? '0 : max_val;
                end else begin
                    w_count_nxt = r_count - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= WIDTH'(RESET_VAL);
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_ovf   <= w_ovf_nxt;
            r_unf   <= w_unf_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr_wrap) begin
            r_wrap <= '0;
        end else if ((w_ovf_nxt || w_unf_nxt) && (r_wrap != '1)) begin
            r_wrap <= r_wrap + 1'b1;
        end
    end

    assign count    = r_count;
    assign at_max   = w_at_max;
    assign at_zero  = w_at_zero;
    assign ovf      = r_ovf;
    assign unf      = r_unf;
    assign wrap_cnt = r_wrap;

endmodule
